branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor_pkg.sv | 24 ++
 rtl/branch_predictor_sat_counter2.sv | 21 ++
 rtl/branch_predictor.sv | 136 +++++++++++++
 tb/tb_branch_predictor.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared constants for the branch predictor: 2-bit counter states, counter
// operations and the RISC-V control-flow opcodes the predictor serves.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } cnt_state_t;

  typedef enum logic [2:0] {
    CNT_HOLD   = 3'd0,
    CNT_INC    = 3'd1,
    CNT_DEC    = 3'd2,
    CNT_SET_ST = 3'd3,
    CNT_SET_WT = 3'd4
  } cnt_op_t;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating counter next-state logic (inc/dec saturate at ST/SNT).
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  cnt_state_t cnt_cur,
  input  cnt_op_t    op,
  output cnt_state_t cnt_nxt
);

  always_comb begin
    cnt_nxt = cnt_cur;
    unique case (op)
      CNT_INC:    if (cnt_cur != ST)  cnt_nxt = cnt_state_t'(cnt_cur + 2'd1);
      CNT_DEC:    if (cnt_cur != SNT) cnt_nxt = cnt_state_t'(cnt_cur - 2'd1);
      CNT_SET_ST: cnt_nxt = ST;
      CNT_SET_WT: cnt_nxt = WT;
      default:    cnt_nxt = cnt_cur;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters; one-cycle registered prediction,
// read-before-write against same-cycle updates, saturating mispredict count.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pred_valid,
  input  logic [XLEN-1:0]  i_pred_pc,
  output logic             o_pred_valid,
  output logic             o_pred_taken,
  output logic [XLEN-1:0]  o_pred_pc,
  input  logic             i_upd_valid,
  input  logic [XLEN-1:0]  i_upd_pc,
  input  logic             i_upd_is_jump,
  input  logic             i_upd_taken,
  input  logic [XLEN-1:0]  i_upd_target,
  input  logic             i_upd_mispredict,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_mispredict_cnt
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic                  valid_q [ENTRIES];
  logic [TAG_W-1:0]      tag_q   [ENTRIES];
  logic [XLEN-1:0]       tgt_q   [ENTRIES];
  cnt_state_t            cnt_q   [ENTRIES];

  logic [IDX-1:0]        pred_idx, upd_idx;
  logic [TAG_W-1:0]      pred_tag, upd_tag;
  logic                  pred_hit, pred_taken_c, upd_hit;
  logic [XLEN-1:0]       pred_pc_c;
  logic                  unused_upd_pc_lo;

  assign pred_idx         = i_pred_pc[IDX+1:2];
  assign pred_tag         = i_pred_pc[XLEN-1:IDX+2];
  assign upd_idx          = i_upd_pc[IDX+1:2];
  assign upd_tag          = i_upd_pc[XLEN-1:IDX+2];
  assign unused_upd_pc_lo = ^i_upd_pc[1:0];

  assign pred_hit     = valid_q[pred_idx] && (tag_q[pred_idx] == pred_tag);
  assign pred_taken_c = pred_hit && cnt_q[pred_idx][1];
  assign pred_pc_c    = pred_taken_c ? tgt_q[pred_idx] : i_pred_pc + XLEN'(4);
  assign upd_hit      = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Update decode: hit refreshes counter/target, taken miss allocates
  cnt_op_t    cnt_op;
  cnt_state_t cnt_nxt;
  logic       upd_wr_cnt, upd_wr_tgt, upd_alloc;

  always_comb begin
    cnt_op     = CNT_HOLD;
    upd_wr_cnt = 1'b0;
    upd_wr_tgt = 1'b0;
    upd_alloc  = 1'b0;
    if (i_upd_valid) begin
      if (upd_hit) begin
        upd_wr_cnt = 1'b1;
        if (i_upd_is_jump) begin
          cnt_op     = CNT_SET_ST;
          upd_wr_tgt = 1'b1;
        end else begin
          cnt_op     = i_upd_taken ? CNT_INC : CNT_DEC;
          upd_wr_tgt = i_upd_taken;
        end
      end else if (i_upd_taken) begin
        upd_alloc  = 1'b1;
        upd_wr_cnt = 1'b1;
        upd_wr_tgt = 1'b1;
        cnt_op     = i_upd_is_jump ? CNT_SET_ST : CNT_SET_WT;
      end
    end
  end

  sat_counter2 u_sat_counter2 (
    .cnt_cur (cnt_q[upd_idx]),
    .op      (cnt_op),
    .cnt_nxt (cnt_nxt)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= WNT;
      end
    end else begin
      if (upd_alloc)  valid_q[upd_idx] <= 1'b1;
      if (upd_wr_cnt) cnt_q[upd_idx]   <= cnt_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      if (upd_alloc)  tag_q[upd_idx] <= upd_tag;
      if (upd_wr_tgt) tgt_q[upd_idx] <= i_upd_target;
    end
  end

  // Stage p1: registered prediction result
  logic             vld_p1, taken_p1;
  logic [XLEN-1:0]  pc_p1;
  logic [CNT_W-1:0] mis_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld_p1    <= 1'b0;
      taken_p1  <= 1'b0;
      pc_p1     <= '0;
      mis_cnt_q <= '0;
    end else begin
      vld_p1 <= i_pred_valid && !i_flush;
      if (i_pred_valid && !i_flush) begin
        taken_p1 <= pred_taken_c;
        pc_p1    <= pred_pc_c;
      end
      if (i_upd_valid && i_upd_mispredict) mis_cnt_q <= sat_inc(mis_cnt_q);
    end
  end

  assign o_pred_valid     = vld_p1;
  assign o_pred_taken     = taken_p1;
  assign o_pred_pc        = pc_p1;
  assign o_mispredict_cnt = mis_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed and randomized checks of branch_predictor against a table model.
module tb_branch_predictor;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;
  localparam int CNT_W   = 4;
  localparam int IDX     = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_pred_valid;
  logic [XLEN-1:0]  i_pred_pc;
  logic             o_pred_valid;
  logic             o_pred_taken;
  logic [XLEN-1:0]  o_pred_pc;
  logic             i_upd_valid;
  logic [XLEN-1:0]  i_upd_pc;
  logic             i_upd_is_jump;
  logic             i_upd_taken;
  logic [XLEN-1:0]  i_upd_target;
  logic             i_upd_mispredict;
  logic             i_flush;
  logic [CNT_W-1:0] o_mispredict_cnt;

  always #5 i_clk = ~i_clk;

  branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_pred_valid     (i_pred_valid),
    .i_pred_pc        (i_pred_pc),
    .o_pred_valid     (o_pred_valid),
    .o_pred_taken     (o_pred_taken),
    .o_pred_pc        (o_pred_pc),
    .i_upd_valid      (i_upd_valid),
    .i_upd_pc         (i_upd_pc),
    .i_upd_is_jump    (i_upd_is_jump),
    .i_upd_taken      (i_upd_taken),
    .i_upd_target     (i_upd_target),
    .i_upd_mispredict (i_upd_mispredict),
    .i_flush          (i_flush),
    .o_mispredict_cnt (o_mispredict_cnt)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: per-entry full PC, target and an integer confidence 0..3
  bit              m_v   [ENTRIES];
  logic [XLEN-1:0] m_pc  [ENTRIES];
  logic [XLEN-1:0] m_tgt [ENTRIES];
  int              m_ctr [ENTRIES];
  logic            e_valid, e_taken;
  logic [XLEN-1:0] e_pc;
  int              e_cnt;

  function automatic int idx_of(input logic [XLEN-1:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic bit hit_at(input logic [XLEN-1:0] pc);
    int i;
    i = idx_of(pc);
    return m_v[i] && ((m_pc[i] >> (IDX + 2)) == (pc >> (IDX + 2)));
  endfunction

  task automatic model_step();
    int  i;
    bit  t;
    if (!i_rst_n) begin
      for (int k = 0; k < ENTRIES; k++) begin
        m_v[k]   = 1'b0;
        m_ctr[k] = 1;
      end
      e_valid = 1'b0; e_taken = 1'b0; e_pc = '0; e_cnt = 0;
      return;
    end
    if (i_pred_valid && !i_flush) begin
      i = idx_of(i_pred_pc);
      t = hit_at(i_pred_pc) && (m_ctr[i] >= 2);
      e_taken = t;
      e_pc    = t ? m_tgt[i] : i_pred_pc + 32'd4;
    end
    e_valid = i_pred_valid && !i_flush;
    if (i_upd_valid) begin
      i = idx_of(i_upd_pc);
      if (hit_at(i_upd_pc)) begin
        if (i_upd_is_jump) begin
          m_ctr[i] = 3;
          m_tgt[i] = i_upd_target;
        end else if (i_upd_taken) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = i_upd_target;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (i_upd_taken) begin
        m_v[i]   = 1'b1;
        m_pc[i]  = i_upd_pc;
        m_tgt[i] = i_upd_target;
        m_ctr[i] = i_upd_is_jump ? 3 : 2;
      end
      if (i_upd_mispredict && e_cnt < CNT_MAX) e_cnt++;
    end
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge i_clk);
    #1;
    check_eq({tag, ".valid"}, 64'(o_pred_valid), 64'(e_valid));
    check_eq({tag, ".taken"}, 64'(o_pred_taken), 64'(e_taken));
    check_eq({tag, ".pc"},    64'(o_pred_pc),    64'(e_pc));
    check_eq({tag, ".miscnt"}, 64'(o_mispredict_cnt), 64'(e_cnt));
  endtask

  task automatic drive(input bit pv, input logic [XLEN-1:0] ppc,
                       input bit uv, input logic [XLEN-1:0] upc, input bit uj,
                       input bit ut, input logic [XLEN-1:0] utgt, input bit um,
                       input bit fl);
    i_pred_valid = pv;  i_pred_pc = ppc;
    i_upd_valid = uv;   i_upd_pc = upc; i_upd_is_jump = uj;
    i_upd_taken = ut;   i_upd_target = utgt; i_upd_mispredict = um;
    i_flush = fl;
  endtask

  function automatic logic [XLEN-1:0] pick_pc();
    case ($urandom_range(0, 3))
      0: return 32'h100 + 32'(4 * ENTRIES * $urandom_range(0, 2));
      1: return 32'(4 * $urandom_range(0, 3 * ENTRIES));
      2: return 32'h200 + 32'(4 * $urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    i_rst_n = 1'b0;
    drive(1, 32'h100, 1, 32'h100, 0, 1, 32'h80, 1, 0);
    cycle("reset0");
    cycle("reset1");
    i_rst_n = 1'b1;

    drive(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);                cycle("pred_cold");
    drive(0, 0, 1, 32'h100, 0, 1, 32'h80, 1, 0);            cycle("upd_br_t");
    drive(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);                cycle("pred_wt");
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 1, 32'h100, 0, 0, 32'h999, 0, 0);         cycle("upd_br_nt");
    end
    drive(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);                cycle("pred_snt");
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 32'h100, 0, 0, 0, 0, 0);               cycle("upd_hold_snt");
    end
    drive(0, 0, 1, 32'h100, 0, 1, 32'h88, 0, 0);            cycle("upd_to_wnt");
    drive(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);                cycle("pred_wnt");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);                      cycle("hold");

    drive(0, 0, 1, 32'h200, 1, 1, 32'h400, 0, 0);           cycle("upd_jump");
    drive(1, 32'h200 + 4 * ENTRIES, 0, 0, 0, 0, 0, 0, 0);  cycle("pred_alias");
    drive(1, 32'h200, 0, 0, 0, 0, 0, 0, 0);                cycle("pred_jump");

    drive(1, 32'h300, 1, 32'h300, 0, 1, 32'h500, 0, 0);     cycle("same_edge");
    drive(1, 32'h300, 0, 0, 0, 0, 0, 0, 0);                cycle("after_same");

    drive(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0);          cycle("pc_wrap");

    for (int k = 0; k < (1 << CNT_W) + 3; k++) begin
      drive(0, 0, 1, 32'h1000, 0, 0, 0, 1, 0);              cycle("mis_sat");
    end
    drive(1, 32'h200, 0, 0, 0, 0, 0, 0, 1);                cycle("flush");

    for (int k = 0; k < 3000; k++) begin
      i_rst_n = ($urandom_range(0, 199) != 0);
      drive($urandom_range(0, 3) != 0, pick_pc(),
            $urandom_range(0, 1) == 1, pick_pc(), $urandom_range(0, 4) == 0,
            $urandom_range(0, 2) != 0, $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
